// File: rtl/seg7_pkg.sv
// Shared glyph codes and segment constants for the multiplexed 7-segment scanner.
package seg7_pkg;

  typedef logic [3:0] glyph_t;

  localparam glyph_t GLYPH_P    = 4'd4;
  localparam glyph_t GLYPH_E    = 4'd5;
  localparam glyph_t GLYPH_N    = 4'd6;
  localparam glyph_t GLYPH_F    = 4'd7;
  localparam glyph_t GLYPH_A    = 4'd8;
  localparam glyph_t GLYPH_I    = 4'd9;
  localparam glyph_t GLYPH_L    = 4'd10;
  localparam glyph_t GLYPH_G    = 4'd11;
  localparam glyph_t GLYPH_C    = 4'd12;
  localparam glyph_t GLYPH_H    = 4'd13;
  localparam glyph_t GLYPH_DASH = 4'd14;
  localparam glyph_t GLYPH_OFF  = 4'd15;

  localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Glyph load bus in, digit-select and segment pins out.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] gbuf;
  logic [NUM_DIGITS-1:0]   dot;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    load;
  logic [NUM_DIGITS-1:0]   seg_sel;
  logic [7:0]              seg;
  logic                    frame_tick;
  logic                    blink_phase;

  modport master (
    output gbuf, dot, blink_mask, load,
    input  seg_sel, seg, frame_tick, blink_phase
  );

  modport slave (
    input  gbuf, dot, blink_mask, load,
    output seg_sel, seg, frame_tick, blink_phase
  );
endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-code to active-low segment decoder, {dot,center,tl,bl,b,br,tr,t}.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  glyph_t     code_i,
  input  logic       dot_i,
  output logic [7:0] seg_o
);

  logic [6:0] segs;

  always_comb begin
    segs = 7'h7F;
    case (code_i)
      4'd0:       segs = 7'h40;
      4'd1:       segs = 7'h79;
      4'd2:       segs = 7'h24;
      4'd3:       segs = 7'h30;
      GLYPH_P:    segs = 7'h0C;
      GLYPH_E:    segs = 7'h06;
      GLYPH_N:    segs = 7'h2B;
      GLYPH_F:    segs = 7'h0E;
      GLYPH_A:    segs = 7'h08;
      GLYPH_I:    segs = 7'h4F;
      GLYPH_L:    segs = 7'h47;
      GLYPH_G:    segs = 7'h42;
      GLYPH_C:    segs = 7'h46;
      GLYPH_H:    segs = 7'h0B;
      GLYPH_DASH: segs = 7'h3F;
      default:    segs = 7'h7F;
    endcase
    seg_o = {~dot_i, segs};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment scanner with double-buffered load, per-digit dot and blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seg7_scan_driver_if.slave      bus
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(SCAN_DIV - 1);
  localparam logic [BlkW-1:0] BlkMax  = BlkW'(BLINK_FRAMES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [BlkW-1:0] bcnt_q, bcnt_d;
  logic            phase_q, phase_d;
  logic            pend_q, pend_d;
  logic            ftick_q, ftick_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;

  logic [NUM_DIGITS-1:0][3:0] stg_code_q, stg_code_d, act_code_q, act_code_d;
  logic [NUM_DIGITS-1:0]      stg_dot_q, stg_dot_d, act_dot_q, act_dot_d;
  logic [NUM_DIGITS-1:0]      stg_blk_q, stg_blk_d, act_blk_q, act_blk_d;

  logic       scan_tick, boundary;
  glyph_t     cur_code;
  logic       cur_dot, cur_blk;
  logic [7:0] dec_seg;

  always_comb begin
    scan_tick = (cnt_q == CntMax);
    boundary  = scan_tick && (idx_q == LastIdx);
    cnt_d     = scan_tick ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (scan_tick) idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    ftick_d   = boundary;
  end

  // A load on the boundary cycle itself is folded into the swap via stg_*_d.
  always_comb begin
    stg_code_d = stg_code_q;
    stg_dot_d  = stg_dot_q;
    stg_blk_d  = stg_blk_q;
    pend_d     = pend_q;
    act_code_d = act_code_q;
    act_dot_d  = act_dot_q;
    act_blk_d  = act_blk_q;
    if (bus.load) begin
      stg_code_d = bus.gbuf;
      stg_dot_d  = bus.dot;
      stg_blk_d  = bus.blink_mask;
      pend_d     = 1'b1;
    end
    if (boundary && pend_d) begin
      act_code_d = stg_code_d;
      act_dot_d  = stg_dot_d;
      act_blk_d  = stg_blk_d;
      pend_d     = 1'b0;
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (boundary) begin
      if (bcnt_q == BlkMax) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Render from next-state values so a swap or phase change shows on digit 0 of the new frame.
  always_comb begin
    cur_code = act_code_d[idx_d];
    cur_dot  = act_dot_d[idx_d];
    cur_blk  = act_blk_d[idx_d];
  end

  seg7_glyph_decode u_decode (
    .code_i (cur_code),
    .dot_i  (cur_dot),
    .seg_o  (dec_seg)
  );

  always_comb begin
    sel_d = sel_q;
    seg_d = seg_q;
    if (scan_tick) begin
      sel_d        = '1;
      sel_d[idx_d] = 1'b0;
      seg_d        = (phase_d && cur_blk) ? SEG_OFF : dec_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= LastIdx;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      pend_q     <= 1'b0;
      ftick_q    <= 1'b0;
      sel_q      <= '1;
      seg_q      <= SEG_OFF;
      stg_code_q <= {NUM_DIGITS{GLYPH_OFF}};
      stg_dot_q  <= '0;
      stg_blk_q  <= '0;
      act_code_q <= {NUM_DIGITS{GLYPH_OFF}};
      act_dot_q  <= '0;
      act_blk_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      pend_q     <= pend_d;
      ftick_q    <= ftick_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      stg_code_q <= stg_code_d;
      stg_dot_q  <= stg_dot_d;
      stg_blk_q  <= stg_blk_d;
      act_code_q <= act_code_d;
      act_dot_q  <= act_dot_d;
      act_blk_q  <= act_blk_d;
    end
  end

  assign bus.seg_sel     = sel_q;
  assign bus.seg         = seg_q;
  assign bus.frame_tick  = ftick_q;
  assign bus.blink_phase = phase_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame/tick-arithmetic reference model.
module tb_seg7_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int BF  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (DIV),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;

  // Reference state: t is the index of the next clock edge since reset release.
  int              t;
  logic [4*N-1:0]  s_gbuf, a_gbuf;
  logic [N-1:0]    s_dot, a_dot, s_blk, a_blk;
  bit              pend;
  logic [N-1:0]    e_sel;
  logic [7:0]      e_seg;
  logic            e_ft, e_bp;

  function automatic logic [7:0] glyph(input logic [3:0] c);
    logic [7:0] lut [16];
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h8C, 8'h86, 8'hAB, 8'h8E,
            8'h88, 8'hCF, 8'hC7, 8'hC2, 8'hC6, 8'h8B, 8'hBF, 8'hFF};
    return lut[c];
  endfunction

  task automatic model_reset();
    s_gbuf = '1; a_gbuf = '1;
    s_dot = '0; a_dot = '0; s_blk = '0; a_blk = '0;
    pend = 0;
    e_sel = '1; e_seg = 8'hFF; e_ft = 1'b0; e_bp = 1'b0;
    t = 0;
  endtask

  task automatic model_edge();
    int n, d;
    bit tick, bnd;
    logic [7:0] g;
    tick = (t % DIV) == DIV - 1;
    n    = t / DIV;
    d    = n % N;
    bnd  = tick && (d == 0);
    if (bus.load) begin
      s_gbuf = bus.gbuf; s_dot = bus.dot; s_blk = bus.blink_mask; pend = 1;
    end
    e_ft = bnd;
    if (bnd) begin
      e_bp = 1'(((n / N + 1) / BF) % 2);
      if (pend) begin
        a_gbuf = s_gbuf; a_dot = s_dot; a_blk = s_blk; pend = 0;
      end
    end
    if (tick) begin
      e_sel    = '1;
      e_sel[d] = 1'b0;
      g        = glyph(a_gbuf[4*d +: 4]);
      e_seg    = (e_bp && a_blk[d]) ? 8'hFF : {~a_dot[d], g[6:0]};
    end
    t++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.gbuf = '0; bus.dot = '0; bus.blink_mask = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vecs++;
    if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {4'b1111, 8'hFF, 2'b00}) begin
      errs++;
      $display("FAIL reset_state got sel=%b seg=%h ft=%b bp=%b", bus.seg_sel, bus.seg,
               bus.frame_tick, bus.blink_phase);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      vecs++;
      if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {e_sel, e_seg, e_ft, e_bp})
      begin
        errs++;
        $display("FAIL idle_scan t=%0d got sel=%b seg=%h ft=%b bp=%b exp sel=%b seg=%h ft=%b bp=%b",
                 t, bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase, e_sel, e_seg, e_ft, e_bp);
      end
      if (t == 4) begin
        vecs++;
        if (bus.seg_sel !== 4'b1110) begin
          errs++;
          $display("FAIL first_tick got sel=%b exp sel=1110", bus.seg_sel);
        end
      end
    end
  endtask

  // Load mid-frame, then follow one frame digit by digit against fixed values.
  task automatic test_open();
    logic [7:0] want [4];
    int waited;
    want = '{8'hAB, 8'h86, 8'h8C, 8'hC0};
    while ((t % 16) != 9) step();
    bus.gbuf = 16'h0456; bus.dot = '0; bus.blink_mask = '0; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    bus.gbuf = 16'h1234;
    vecs++;
    if (bus.seg !== 8'hFF) begin
      errs++;
      $display("FAIL open_no_early got seg=%h exp seg=ff", bus.seg);
    end
    waited = 0;
    while (!bus.frame_tick && waited < 40) begin
      step();
      waited++;
      vecs++;
      if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {e_sel, e_seg, e_ft, e_bp})
      begin
        errs++;
        $display("FAIL open_wait t=%0d got sel=%b seg=%h ft=%b exp sel=%b seg=%h ft=%b",
                 t, bus.seg_sel, bus.seg, bus.frame_tick, e_sel, e_seg, e_ft);
      end
    end
    vecs++;
    if (!bus.frame_tick) begin
      errs++;
      $display("FAIL open_boundary_timeout got ft=0 exp ft=1 within 40 cycles");
    end
    for (int dg = 0; dg < 4; dg++) begin
      vecs++;
      if (bus.seg !== want[dg] || bus.seg_sel[dg] !== 1'b0) begin
        errs++;
        $display("FAIL open_digit%0d got sel=%b seg=%h exp seg=%h", dg, bus.seg_sel, bus.seg,
                 want[dg]);
      end
      for (int k = 0; k < 4; k++) begin
        step();
        vecs++;
        if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {e_sel, e_seg, e_ft, e_bp})
        begin
          errs++;
          $display("FAIL open_scan t=%0d got sel=%b seg=%h ft=%b exp sel=%b seg=%h ft=%b",
                   t, bus.seg_sel, bus.seg, bus.frame_tick, e_sel, e_seg, e_ft);
        end
      end
    end
  endtask

  // Load A mid-frame, then B on the boundary cycle itself; only B may reach the display.
  task automatic test_last_wins();
    logic [15:0] a, b;
    logic [7:0]  g;
    b = 16'($urandom_range(0, 16'hEEEE));
    a = ~b;
    while ((t % 16) != 8) step();
    bus.gbuf = a; bus.dot = '0; bus.blink_mask = '0; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while ((t % 16) != 3) step();
    bus.gbuf = b; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    g = glyph(b[3:0]);
    vecs++;
    if (bus.seg !== g || bus.frame_tick !== 1'b1) begin
      errs++;
      $display("FAIL last_wins_digit0 got seg=%h ft=%b exp seg=%h ft=1", bus.seg, bus.frame_tick, g);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      vecs++;
      if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {e_sel, e_seg, e_ft, e_bp})
      begin
        errs++;
        $display("FAIL last_wins t=%0d got sel=%b seg=%h exp sel=%b seg=%h",
                 t, bus.seg_sel, bus.seg, e_sel, e_seg);
      end
    end
  endtask

  task automatic test_dot();
    while ((t % 16) != 10) step();
    bus.gbuf = 16'hFF3F; bus.dot = 4'b0010; bus.blink_mask = '0; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    bus.dot = '0;
    while ((t % 16) != 4) step();
    for (int i = 0; i < 16; i++) begin
      if ((i % 4) == 0) begin
        vecs++;
        if (bus.seg !== ((i == 4) ? 8'h30 : 8'hFF)) begin
          errs++;
          $display("FAIL dot_digit%0d got seg=%h exp seg=%h", i / 4, bus.seg,
                   (i == 4) ? 8'h30 : 8'hFF);
        end
      end
      step();
      vecs++;
      if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {e_sel, e_seg, e_ft, e_bp})
      begin
        errs++;
        $display("FAIL dot_scan t=%0d got sel=%b seg=%h exp sel=%b seg=%h",
                 t, bus.seg_sel, bus.seg, e_sel, e_seg);
      end
    end
  endtask

  task automatic test_blink();
    bus.gbuf = {12'($urandom_range(0, 12'hFFF)), 4'h3};
    bus.dot = 4'($urandom_range(0, 15)) & 4'b1110;
    bus.blink_mask = 4'b0001; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 6 * 16; i++) begin
      step();
      vecs++;
      if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {e_sel, e_seg, e_ft, e_bp})
      begin
        errs++;
        $display("FAIL blink t=%0d got sel=%b seg=%h ft=%b bp=%b exp sel=%b seg=%h ft=%b bp=%b",
                 t, bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase, e_sel, e_seg, e_ft, e_bp);
      end
    end
  endtask

  // Inputs toggle every cycle; only occasional loads may affect the display.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.gbuf       = 16'($urandom);
      bus.dot        = 4'($urandom);
      bus.blink_mask = 4'($urandom);
      bus.load       = ($urandom_range(0, 7) == 0);
      step();
      vecs++;
      if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {e_sel, e_seg, e_ft, e_bp})
      begin
        errs++;
        $display("FAIL random t=%0d got sel=%b seg=%h ft=%b bp=%b exp sel=%b seg=%h ft=%b bp=%b",
                 t, bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase, e_sel, e_seg, e_ft, e_bp);
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_reset_pending();
    while ((t % 16) != 6) step();
    bus.gbuf = 16'h0123; bus.dot = 4'b1111; bus.blink_mask = '0; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    vecs++;
    if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {4'b1111, 8'hFF, 2'b00}) begin
      errs++;
      $display("FAIL async_reset got sel=%b seg=%h ft=%b bp=%b exp sel=1111 seg=ff ft=0 bp=0",
               bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      vecs++;
      if ({bus.seg_sel, bus.seg, bus.frame_tick, bus.blink_phase} !== {e_sel, e_seg, e_ft, e_bp})
      begin
        errs++;
        $display("FAIL reset_pending t=%0d got sel=%b seg=%h exp sel=%b seg=%h",
                 t, bus.seg_sel, bus.seg, e_sel, e_seg);
      end
      vecs++;
      if (bus.seg !== 8'hFF) begin
        errs++;
        $display("FAIL reset_dark t=%0d got seg=%h exp seg=ff", t, bus.seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_last_wins();
    test_dot();
    test_blink();
    test_random();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised N-digit multiplexed 7-segment scanner. Successor to the fixed 4-digit renderer: digit count, scan rate and blink rate are parametrised.
- Adds per-digit decimal point, per-digit blink and a double-buffered load so display content never tears mid-frame.
- Sits between the top-level state/display logic, which writes 4-bit glyph codes, and the board's digit-select and segment pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; legal range 1..8.
- SCAN_DIV, 100000: clk cycles each digit is held; minimum 2.
- BLINK_FRAMES, 8: full scan frames per blink half-period; minimum 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- gbuf  input  4*NUM_DIGITS  glyph codes; [3:0] = digit 0 (rightmost)
- dot  input  NUM_DIGITS  decimal point request per digit
- blink_mask  input  NUM_DIGITS  digit blinks when bit set
- load  input  1  one-cycle strobe; captures gbuf/dot/blink_mask into staging
- seg_sel  output  NUM_DIGITS  digit select, active-low, one-cold
- seg  output  8  segments, active-low, {dot,center,tl,bl,b,br,tr,t}
- frame_tick  output  1  one-cycle pulse at each frame boundary
- blink_phase  output  1  current blink phase (1 = blinking digits dark)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - seg_sel all 1s, seg 8'hFF, frame_tick 0, blink_phase 0.
  - Prescaler 0, digit index NUM_DIGITS-1, blink counter 0, pending 0.
  - Staging and active buffers: codes 4'hF, dot 0, blink 0.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. scan_tick is asserted while count == SCAN_DIV-1.
- Digit advance: on a scan_tick edge, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - First tick after reset shows digit 0; outputs stay dark until then.
- Frame boundary: the scan_tick edge where idx wraps to 0.
  - frame_tick is high for exactly the one cycle following that edge.
  - With NUM_DIGITS=1, every tick is a boundary.
- Load, double buffer:
  - load=1 copies the inputs into staging and sets pending.
  - Repeated loads before a boundary: last one wins.
  - At the boundary, if pending (or load is high that same cycle, using that cycle's inputs), active <= staging and pending clears.
  - Digit 0 of the new frame is rendered from the newly swapped data.
  - Input changes without load never affect the display.
- Outputs: registered, updated only on scan_tick edges.
  - seg_sel: bit idx = 0, all other bits = 1.
  - seg[6:0] = decode(active code[idx]).
  - seg[7] = ~active dot[idx].
  - If blink_phase=1 and active blink[idx]=1, seg = 8'hFF (select still asserted).
- Decode, hex for seg[7:0] with dot off:
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 'P' 8C, 5 'E' 86, 6 'n' AB, 7 'F' 8E.
  - 8 'A' 88, 9 'I' CF, 10 'L' C7, 11 'g' C2, 12 'C' C6, 13 'h' 8B, 14 '-' BF, 15 off FF.
  - Code 15 with dot=1 gives 7F.
- Blink:
  - The frame counter counts boundaries 0..BLINK_FRAMES-1.
  - On the boundary that wraps it, blink_phase toggles; the new phase applies from digit 0 of that frame.
- Width rules: idx width = max(1, clog2(NUM_DIGITS)). Prescaler width = clog2(SCAN_DIV).
- Reset mid-frame: all state returns to reset values immediately; any pending load is discarded.

Decomposition:
- Shared package seg7_pkg:
  - Glyph code constants: GLYPH_P=4, GLYPH_E=5, GLYPH_N=6, GLYPH_F=7, GLYPH_A=8, GLYPH_I=9, GLYPH_L=10, GLYPH_G=11, GLYPH_C=12, GLYPH_H=13, GLYPH_DASH=14, GLYPH_OFF=15.
  - SEG_OFF = 8'hFF.
- One sub-module: seg7_glyph_decode. Combinational, 4-bit code plus dot in, 8-bit active-low segments out, table as above.

Test Plan (all with NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2):
- Reset then idle -> seg_sel=1111, seg=FF until first tick (cycle 3 edge); then seg_sel cycles 1110,1101,1011,0111 every 4 clk; seg=FF throughout (buffers off).
- load gbuf=16'h0456 mid-frame -> no change until next boundary; then digits 0..3 show AB,86,8C,C0 ("OPEn"); frame_tick pulses once per 16 clk.
- load A then B in the same frame, B on the boundary cycle -> only B displayed; A never appears.
- dot=4'b0010, gbuf=16'hFF3F -> digit 1 seg=30; digits 0, 2 and 3 seg=FF.
- blink_mask=4'b0001, gbuf digit0=3 -> digit 0 shows B0 for 2 frames and FF for 2 frames, alternating; blink_phase toggles every 32 clk; other digits unaffected.
- rst_n low for 1 cycle mid-scan with load pending -> outputs FF/1111 at once; after release the display stays dark (pending load discarded).
